// File: rtl/matmul_mem_responder.sv
// rtl/matmul_mem_responder.sv - fixed-latency A/B/C region memory for the matmul engine plus a host access port
// Engine ports are never stalled; the host port yields whenever the engine touches the same region.
module matmul_mem_responder #(
  parameter int DEPTH = 4,
  parameter int DW    = 32,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          mem_read_en_A,
  input  logic [AW-1:0] mem_addr_A,
  output logic [DW-1:0] mem_data_A,
  input  logic          mem_read_en_B,
  input  logic [AW-1:0] mem_addr_B,
  output logic [DW-1:0] mem_data_B,
  input  logic          mem_write_en_C,
  input  logic [AW-1:0] mem_addr_C,
  input  logic [DW-1:0] mem_data_C,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_ack,
  output logic [DW-1:0] host_rdata,
  output logic          host_err,
  output logic [2:0]    err_flags,
  input  logic          err_clr,
  output logic [7:0]    c_wr_cnt
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0] DEPTH_L = 8'(DEPTH);

  typedef enum logic {S_IDLE, S_ACK} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] mem_a_q [DEPTH];
  logic [DW-1:0] mem_a_d [DEPTH];
  logic [DW-1:0] mem_b_q [DEPTH];
  logic [DW-1:0] mem_b_d [DEPTH];
  logic [DW-1:0] mem_c_q [DEPTH];
  logic [DW-1:0] mem_c_d [DEPTH];
  logic [DW-1:0] mem_data_a_q, mem_data_a_d;
  logic [DW-1:0] mem_data_b_q, mem_data_b_d;
  logic          host_ack_q, host_ack_d;
  logic [DW-1:0] host_rdata_q, host_rdata_d;
  logic          host_err_q, host_err_d;
  logic [2:0]    err_flags_q, err_flags_d;
  logic [7:0]    c_wr_cnt_q, c_wr_cnt_d;

  logic [2:0]    err_new;
  logic          a_ok, b_ok, c_ok, host_ok, host_conflict;
  logic [1:0]    host_region;
  logic [IW-1:0] host_idx;

  always_comb begin
    mem_a_d      = mem_a_q;
    mem_b_d      = mem_b_q;
    mem_c_d      = mem_c_q;
    state_d      = state_q;
    host_ack_d   = 1'b0;
    host_rdata_d = host_rdata_q;
    host_err_d   = host_err_q;
    mem_data_a_d = mem_data_a_q;
    mem_data_b_d = mem_data_b_q;
    c_wr_cnt_d   = c_wr_cnt_q;
    err_new      = 3'b000;

    a_ok = (mem_addr_A[9:8] == 2'b00) && (mem_addr_A[7:0] < DEPTH_L);
    b_ok = (mem_addr_B[9:8] == 2'b01) && (mem_addr_B[7:0] < DEPTH_L);
    c_ok = (mem_addr_C[9:8] == 2'b10) && (mem_addr_C[7:0] < DEPTH_L);

    if (mem_read_en_A) begin
      if (a_ok) mem_data_a_d = mem_a_q[mem_addr_A[IW-1:0]];
      else begin
        mem_data_a_d = '0;
        err_new[0]   = 1'b1;
      end
    end
    if (mem_read_en_B) begin
      if (b_ok) mem_data_b_d = mem_b_q[mem_addr_B[IW-1:0]];
      else begin
        mem_data_b_d = '0;
        err_new[1]   = 1'b1;
      end
    end
    if (mem_write_en_C) begin
      if (c_ok) begin
        mem_c_d[mem_addr_C[IW-1:0]] = mem_data_C;
        if (c_wr_cnt_q != 8'hFF) c_wr_cnt_d = c_wr_cnt_q + 8'd1;
      end else begin
        err_new[2] = 1'b1;
      end
    end
    // A fresh error outranks a same-cycle clear
    err_flags_d = (err_clr ? 3'b000 : err_flags_q) | err_new;

    host_region   = host_addr[9:8];
    host_idx      = host_addr[IW-1:0];
    host_ok       = (host_region != 2'b11) && (host_addr[7:0] < DEPTH_L);
    host_conflict = ((host_region == 2'b00) && mem_read_en_A) ||
                    ((host_region == 2'b01) && mem_read_en_B) ||
                    ((host_region == 2'b10) && mem_write_en_C);

    case (state_q)
      S_IDLE: begin
        if (host_req && !host_conflict) begin
          state_d      = S_ACK;
          host_ack_d   = 1'b1;
          host_err_d   = !host_ok;
          host_rdata_d = '0;
          if (host_ok) begin
            if (host_we) begin
              case (host_region)
                2'b00:   mem_a_d[host_idx] = host_wdata;
                2'b01:   mem_b_d[host_idx] = host_wdata;
                default: mem_c_d[host_idx] = host_wdata;
              endcase
            end else begin
              case (host_region)
                2'b00:   host_rdata_d = mem_a_q[host_idx];
                2'b01:   host_rdata_d = mem_b_q[host_idx];
                default: host_rdata_d = mem_c_q[host_idx];
              endcase
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_a_q[i] <= '0;
        mem_b_q[i] <= '0;
        mem_c_q[i] <= '0;
      end
      state_q      <= S_IDLE;
      host_ack_q   <= 1'b0;
      host_rdata_q <= '0;
      host_err_q   <= 1'b0;
      mem_data_a_q <= '0;
      mem_data_b_q <= '0;
      err_flags_q  <= 3'b000;
      c_wr_cnt_q   <= 8'd0;
    end else begin
      mem_a_q      <= mem_a_d;
      mem_b_q      <= mem_b_d;
      mem_c_q      <= mem_c_d;
      state_q      <= state_d;
      host_ack_q   <= host_ack_d;
      host_rdata_q <= host_rdata_d;
      host_err_q   <= host_err_d;
      mem_data_a_q <= mem_data_a_d;
      mem_data_b_q <= mem_data_b_d;
      err_flags_q  <= err_flags_d;
      c_wr_cnt_q   <= c_wr_cnt_d;
    end
  end

  assign mem_data_A = mem_data_a_q;
  assign mem_data_B = mem_data_b_q;
  assign host_ack   = host_ack_q;
  assign host_rdata = host_rdata_q;
  assign host_err   = host_err_q;
  assign err_flags  = err_flags_q;
  assign c_wr_cnt   = c_wr_cnt_q;
endmodule

// File: tb/tb_matmul_mem_responder.sv
// tb/tb_matmul_mem_responder.sv - directed vector bench for matmul_mem_responder
// Engine-port vectors come from a table; host handshakes, stalls, saturation and reset are hand sequences.
module tb_matmul_mem_responder;
  logic        clk = 1'b0;
  logic        rstn;
  logic        mem_read_en_A, mem_read_en_B, mem_write_en_C;
  logic [9:0]  mem_addr_A, mem_addr_B, mem_addr_C;
  logic [31:0] mem_data_A, mem_data_B, mem_data_C;
  logic        host_req, host_we, host_ack, host_err, err_clr;
  logic [9:0]  host_addr;
  logic [31:0] host_wdata, host_rdata;
  logic [2:0]  err_flags;
  logic [7:0]  c_wr_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  matmul_mem_responder #(.DEPTH(4), .DW(32), .AW(10)) dut (
    .clk(clk), .rstn(rstn),
    .mem_read_en_A(mem_read_en_A), .mem_addr_A(mem_addr_A), .mem_data_A(mem_data_A),
    .mem_read_en_B(mem_read_en_B), .mem_addr_B(mem_addr_B), .mem_data_B(mem_data_B),
    .mem_write_en_C(mem_write_en_C), .mem_addr_C(mem_addr_C), .mem_data_C(mem_data_C),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata), .host_err(host_err),
    .err_flags(err_flags), .err_clr(err_clr), .c_wr_cnt(c_wr_cnt)
  );

  typedef struct {
    logic re_a; logic [9:0] a_a;
    logic re_b; logic [9:0] a_b;
    logic we_c; logic [9:0] a_c; logic [31:0] d_c;
    logic clr;
    logic [31:0] x_a; logic [31:0] x_b; logic [2:0] x_err; logic [7:0] x_cnt;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_engine();
    mem_read_en_A = 0; mem_read_en_B = 0; mem_write_en_C = 0; err_clr = 0;
    mem_addr_A = '0; mem_addr_B = '0; mem_addr_C = '0; mem_data_C = '0;
  endtask

  task automatic host_op(input logic we, input logic [9:0] addr, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er, output int cyc);
    host_req = 1; host_we = we; host_addr = addr; host_wdata = wd;
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!host_ack && cyc < 10);
    rd = host_rdata;
    er = host_err;
    if (!host_ack) begin
      n_cmp++; n_fail++;
      $display("FAIL host_timeout: addr %h no ack after %0d cycles", addr, cyc);
    end
    host_req = 0; host_we = 0;
    step();
  endtask

  initial begin
    vec_t        vt[15];
    logic [31:0] rd;
    logic        er;
    int          cyc;

    vt[0]  = '{1, 10'h002, 0, 10'h000, 0, 10'h000, 32'h0,        0, 32'h04030201, 32'h0,  3'b000, 8'd0};
    vt[1]  = '{0, 10'h000, 0, 10'h000, 0, 10'h000, 32'h0,        0, 32'h04030201, 32'h0,  3'b000, 8'd0};
    vt[2]  = '{0, 10'h000, 0, 10'h000, 1, 10'h200, 32'h0A0B0C0D, 0, 32'h04030201, 32'h0,  3'b000, 8'd1};
    vt[3]  = '{1, 10'h004, 0, 10'h000, 0, 10'h000, 32'h0,        0, 32'h0,        32'h0,  3'b001, 8'd1};
    vt[4]  = '{0, 10'h000, 0, 10'h000, 1, 10'h005, 32'hDEADBEEF, 0, 32'h0,        32'h0,  3'b101, 8'd1};
    vt[5]  = '{0, 10'h000, 0, 10'h000, 0, 10'h000, 32'h0,        1, 32'h0,        32'h0,  3'b000, 8'd1};
    vt[6]  = '{1, 10'h100, 0, 10'h000, 0, 10'h000, 32'h0,        1, 32'h0,        32'h0,  3'b001, 8'd1};
    vt[7]  = '{0, 10'h000, 0, 10'h000, 0, 10'h000, 32'h0,        1, 32'h0,        32'h0,  3'b000, 8'd1};
    vt[8]  = '{0, 10'h000, 0, 10'h000, 1, 10'h203, 32'h00000011, 0, 32'h0,        32'h0,  3'b000, 8'd2};
    vt[9]  = '{1, 10'h002, 1, 10'h100, 0, 10'h000, 32'h0,        0, 32'h04030201, 32'hB0, 3'b000, 8'd2};
    vt[10] = '{0, 10'h000, 1, 10'h104, 0, 10'h000, 32'h0,        0, 32'h04030201, 32'h0,  3'b010, 8'd2};
    vt[11] = '{0, 10'h000, 1, 10'h101, 0, 10'h000, 32'h0,        1, 32'h04030201, 32'hB1, 3'b000, 8'd2};
    vt[12] = '{0, 10'h000, 0, 10'h000, 1, 10'h300, 32'h77,       0, 32'h04030201, 32'hB1, 3'b100, 8'd2};
    vt[13] = '{1, 10'h202, 0, 10'h000, 0, 10'h000, 32'h0,        1, 32'h0,        32'hB1, 3'b001, 8'd2};
    vt[14] = '{0, 10'h000, 0, 10'h000, 0, 10'h000, 32'h0,        1, 32'h0,        32'hB1, 3'b000, 8'd2};

    rstn = 0;
    idle_engine();
    host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data_a", mem_data_A, 32'h0);
    chk("rst_data_b", mem_data_B, 32'h0);
    chk("rst_ack", {31'h0, host_ack}, 32'h0);
    chk("rst_err_flags", {29'h0, err_flags}, 32'h0);
    chk("rst_cnt", {24'h0, c_wr_cnt}, 32'h0);
    rstn = 1;
    step();

    host_op(1, 10'h002, 32'h04030201, rd, er, cyc);
    chk("hw002_latency", cyc, 1);
    chk("hw002_err", {31'h0, er}, 32'h0);
    host_op(1, 10'h100, 32'hB0, rd, er, cyc);
    host_op(1, 10'h101, 32'hB1, rd, er, cyc);
    mem_read_en_A = 1; mem_addr_A = 10'h002;
    step();
    chk("ra002_data", mem_data_A, 32'h04030201);
    idle_engine();
    step();
    chk("ra002_hold", mem_data_A, 32'h04030201);

    for (int i = 0; i < 15; i++) begin
      mem_read_en_A = vt[i].re_a; mem_addr_A = vt[i].a_a;
      mem_read_en_B = vt[i].re_b; mem_addr_B = vt[i].a_b;
      mem_write_en_C = vt[i].we_c; mem_addr_C = vt[i].a_c; mem_data_C = vt[i].d_c;
      err_clr = vt[i].clr;
      step();
      chk($sformatf("v%0d_data_a", i), mem_data_A, vt[i].x_a);
      chk($sformatf("v%0d_data_b", i), mem_data_B, vt[i].x_b);
      chk($sformatf("v%0d_err_flags", i), {29'h0, err_flags}, {29'h0, vt[i].x_err});
      chk($sformatf("v%0d_cnt", i), {24'h0, c_wr_cnt}, {24'h0, vt[i].x_cnt});
      idle_engine();
    end

    host_op(0, 10'h200, 32'h0, rd, er, cyc);
    chk("hr200_data", rd, 32'h0A0B0C0D);
    host_op(0, 10'h203, 32'h0, rd, er, cyc);
    chk("hr203_data", rd, 32'h00000011);
    host_op(0, 10'h201, 32'h0, rd, er, cyc);
    chk("hr201_untouched", rd, 32'h0);

    // Host read of B collides with engine read of B: one stall cycle
    host_req = 1; host_we = 0; host_addr = 10'h101;
    mem_read_en_B = 1; mem_addr_B = 10'h100;
    step();
    chk("stall_no_ack", {31'h0, host_ack}, 32'h0);
    chk("stall_data_b", mem_data_B, 32'hB0);
    idle_engine();
    step();
    chk("stall_ack", {31'h0, host_ack}, 32'h1);
    chk("stall_rdata", host_rdata, 32'hB1);
    host_req = 0;
    step();
    chk("ack_one_cycle", {31'h0, host_ack}, 32'h0);

    host_op(0, 10'h300, 32'h0, rd, er, cyc);
    chk("hr300_err", {31'h0, er}, 32'h1);
    chk("hr300_rdata", rd, 32'h0);
    host_op(0, 10'h104, 32'h0, rd, er, cyc);
    chk("hr104_err", {31'h0, er}, 32'h1);
    host_op(1, 10'h202, 32'h12345678, rd, er, cyc);
    chk("hw202_no_cnt", {24'h0, c_wr_cnt}, 32'd2);

    for (int i = 0; i < 260; i++) begin
      mem_write_en_C = 1; mem_addr_C = 10'h200; mem_data_C = i;
      step();
      if (i == 252) chk("cnt_reach_255", {24'h0, c_wr_cnt}, 32'd255);
    end
    idle_engine();
    step();
    chk("cnt_saturated", {24'h0, c_wr_cnt}, 32'd255);
    host_op(0, 10'h200, 32'h0, rd, er, cyc);
    chk("hr200_last", rd, 32'd259);

    host_op(1, 10'h002, 32'h55, rd, er, cyc);
    host_req = 1; host_we = 0; host_addr = 10'h002;
    step();
    chk("pre_rst_ack", {31'h0, host_ack}, 32'h1);
    rstn = 0;
    #1;
    chk("async_rst_ack", {31'h0, host_ack}, 32'h0);
    chk("async_rst_cnt", {24'h0, c_wr_cnt}, 32'h0);
    chk("async_rst_data_a", mem_data_A, 32'h0);
    host_req = 0;
    @(posedge clk);
    #1;
    rstn = 1;
    step();
    host_op(0, 10'h002, 32'h0, rd, er, cyc);
    chk("post_rst_mem", rd, 32'h0);
    chk("post_rst_err", {31'h0, er}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
